nfc_tx_framer: RTL



---
 rtl/nfc_pkg.sv | 41 ++++
 rtl/nfc_crc_a.sv | 55 +++++
 rtl/nfc_tx_framer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nfc_pkg.sv
// -----------------------------------------------------------------------------
// nfc_pkg
// Shared definitions for the ISO14443A PCD->PICC transmit framer:
//   - state_t     : framer state encoding (CRC states only present when
//                   NFC_TX_CRC_EN is defined)
//   - miller_t    : Modified-Miller symbol codes X / Y / Z
//   - CRC_A_INIT / CRC_A_POLY : CRC_A seed and reflected polynomial
//   - odd_parity(): ISO14443A odd parity bit for one byte
// Build option: `define NFC_TX_CRC_EN to enable CRC_A append.
// -----------------------------------------------------------------------------
package nfc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SOF    = 3'd1,
        ST_DATA   = 3'd2,
`ifdef NFC_TX_CRC_EN
        ST_CRC_LO = 3'd3,
        ST_CRC_HI = 3'd4,
`endif
        ST_EOF0   = 3'd5,
        ST_EOF1   = 3'd6,
        ST_GAP    = 3'd7
    } state_t;

    // X: pause in second half, Y: no pause, Z: pause at symbol start
    typedef enum logic [1:0] {
        MILLER_X = 2'd0,
        MILLER_Y = 2'd1,
        MILLER_Z = 2'd2
    } miller_t;

    localparam logic [15:0] CRC_A_INIT = 16'h6363;
    localparam logic [15:0] CRC_A_POLY = 16'h8408;

    // Odd parity: the 9-bit character always carries an odd number of ones
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/nfc_crc_a.sv
// -----------------------------------------------------------------------------
// nfc_crc_a
// Byte-wide CRC_A (ISO14443A) accumulator, reflected form, LSB first.
// Only compiled when NFC_TX_CRC_EN is defined.
// Ports:
//   clk      in   system clock
//   rstn     in   synchronous active-low reset (crc returns to CRC_A_INIT)
//   clear    in   restart from CRC_A_INIT; combined with byte_en the byte is
//                 folded into the fresh seed
//   byte_en  in   fold byte_in into the running CRC
//   byte_in  in   data byte
//   crc      out  current CRC, updated the cycle after byte_en
// -----------------------------------------------------------------------------
`ifdef NFC_TX_CRC_EN
module nfc_crc_a
    import nfc_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc
);

    logic [15:0] r_crc;
    logic [15:0] w_base;

    function automatic logic [15:0] crc_a_byte(input logic [15:0] c,
                                               input logic [7:0]  b);
        logic [15:0] v;
        v = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            v = v[0] ? ((v >> 1) ^ CRC_A_POLY) : (v >> 1);
        end
        return v;
    endfunction

    // First byte of a frame is folded into the seed, not the stale CRC
    assign w_base = clear ? CRC_A_INIT : r_crc;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_crc <= CRC_A_INIT;
        end else if (byte_en) begin
            r_crc <= crc_a_byte(w_base, byte_in);
        end else if (clear) begin
            r_crc <= CRC_A_INIT;
        end
    end

    assign crc = r_crc;

endmodule
`endif

// File: rtl/nfc_tx_framer.sv
// -----------------------------------------------------------------------------
// nfc_tx_framer
// ISO14443A reader-to-card transmit framer (106 kbit/s, Modified Miller).
// Drains the TX byte FIFO through a ready/valid handshake, sends
// SOF, data bytes (LSB first + odd parity), optional CRC_A, EOF, then holds
// off for a guard gap.
// Build option: NFC_TX_CRC_EN -- append CRC_A (low byte first) after the last
// data byte. Undefined: no CRC logic or CRC states.
// Parameters:
//   BIT_CYCLES   clocks per symbol (even, >= 8)
//   PAUSE_CYCLES carrier pause length (< BIT_CYCLES/2)
//   GAP_CYCLES   idle clocks after EOF before the next frame
// Ports:
//   clk          in   system clock
//   rstn         in   synchronous active-low reset
//   in_rdy       out  byte can be accepted this cycle (combinational)
//   in_en        in   FIFO output valid
//   in_data      in   [7:0] byte, [8] last byte of frame
//   tx_pause     out  1 = carrier paused (registered)
//   busy         out  frame in progress incl. gap (registered)
//   err_underrun out  one-cycle pulse: FIFO empty mid-frame (registered)
// -----------------------------------------------------------------------------
module nfc_tx_framer
    import nfc_pkg::*;
#(
    parameter int BIT_CYCLES   = 128,
    parameter int PAUSE_CYCLES = 40,
    parameter int GAP_CYCLES   = 1024
) (
    input  logic       clk,
    input  logic       rstn,
    output logic       in_rdy,
    input  logic       in_en,
    input  logic [8:0] in_data,
    output logic       tx_pause,
    output logic       busy,
    output logic       err_underrun
);

    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int HALF  = BIT_CYCLES / 2;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [GAP_W-1:0] w_gap_cnt_nxt;
    logic [3:0]       r_bit_idx;
    logic [3:0]       w_bit_idx_nxt;
    logic [8:0]       r_shift;
    logic [8:0]       w_shift_nxt;
    logic             r_prev_zero;
    logic             w_prev_zero_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             r_tx_pause;
    logic             r_busy;
    logic             r_err;

    logic             w_in_rdy;
    logic             w_pause_nxt;
    logic             w_err_nxt;
    logic             w_load_byte;
    logic             w_sym_end;
    logic             w_byte_end;
    logic             w_cnt_run;
    miller_t          w_sym;
    miller_t          w_data_sym;

`ifdef NFC_TX_CRC_EN
    logic [15:0]      w_crc;
    logic             w_crc_clear;

    // A byte accepted in IDLE starts a new frame, so the CRC restarts with it
    assign w_crc_clear = w_load_byte && (r_state == ST_IDLE);

    nfc_crc_a u_crc (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (w_crc_clear),
        .byte_en (w_load_byte),
        .byte_in (in_data[7:0]),
        .crc     (w_crc)
    );
`endif

    // Pause window of a symbol as a function of the symbol clock index
    function automatic logic miller_pause(input miller_t s,
                                          input logic [CNT_W-1:0] c);
        logic p;
        p = 1'b0;
        case (s)
            MILLER_Z: p = (c < CNT_W'(PAUSE_CYCLES));
            MILLER_X: p = (c >= CNT_W'(HALF)) &&
                          (c <  CNT_W'(HALF + PAUSE_CYCLES));
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

    assign w_sym_end  = (r_cnt == CNT_W'(BIT_CYCLES - 1));
    assign w_byte_end = w_sym_end && (r_bit_idx == 4'd8);

    // A zero after a zero (or after SOF) needs a pause to stay decodable
    assign w_data_sym = r_shift[0]  ? MILLER_X :
                        r_prev_zero ? MILLER_Z : MILLER_Y;

    // State register and control
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_gap_cnt   <= '0;
            r_bit_idx   <= '0;
            r_prev_zero <= 1'b1;
            r_last      <= 1'b0;
            r_tx_pause  <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_prev_zero <= w_prev_zero_nxt;
            r_last      <= w_last_nxt;
            r_tx_pause  <= w_pause_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_err       <= w_err_nxt;
        end
    end

    // Shift register is pure data: always overwritten on load
    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    // Next-state and symbol generation
    always_comb begin
        w_state_nxt     = r_state;
        w_gap_cnt_nxt   = '0;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_prev_zero_nxt = r_prev_zero;
        w_last_nxt      = r_last;
        w_in_rdy        = 1'b0;
        w_err_nxt       = 1'b0;
        w_load_byte     = 1'b0;
        w_cnt_run       = 1'b0;
        w_sym           = MILLER_Y;

        case (r_state)
            ST_IDLE: begin
                w_in_rdy = 1'b1;
                if (in_en) begin
                    w_load_byte = 1'b1;
                    w_state_nxt = ST_SOF;
                end
            end

            ST_SOF: begin
                w_cnt_run = 1'b1;
                w_sym     = MILLER_Z;
                if (w_sym_end) begin
                    // SOF counts as a logic 0 for the first data bit
                    w_prev_zero_nxt = 1'b1;
                    w_state_nxt     = ST_DATA;
                end
            end

            ST_DATA: begin
                w_cnt_run = 1'b1;
                w_sym     = w_data_sym;
                if (w_sym_end) begin
                    w_shift_nxt     = {1'b0, r_shift[8:1]};
                    w_bit_idx_nxt   = r_bit_idx + 4'd1;
                    w_prev_zero_nxt = ~r_shift[0];
                end
                if (w_byte_end) begin
                    if (r_last) begin
`ifdef NFC_TX_CRC_EN
                        w_shift_nxt   = {odd_parity(w_crc[7:0]), w_crc[7:0]};
                        w_bit_idx_nxt = 4'd0;
                        w_state_nxt   = ST_CRC_LO;
`else
                        w_state_nxt   = ST_EOF0;
`endif
                    end else begin
                        // Handoff on the final parity clock keeps symbols contiguous
                        w_in_rdy = 1'b1;
                        if (in_en) begin
                            w_load_byte = 1'b1;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_EOF0;
                        end
                    end
                end
            end

`ifdef NFC_TX_CRC_EN
            ST_CRC_LO: begin
                w_cnt_run = 1'b1;
                w_sym     = w_data_sym;
                if (w_sym_end) begin
                    w_shift_nxt     = {1'b0, r_shift[8:1]};
                    w_bit_idx_nxt   = r_bit_idx + 4'd1;
                    w_prev_zero_nxt = ~r_shift[0];
                end
                if (w_byte_end) begin
                    w_shift_nxt   = {odd_parity(w_crc[15:8]), w_crc[15:8]};
                    w_bit_idx_nxt = 4'd0;
                    w_state_nxt   = ST_CRC_HI;
                end
            end

            ST_CRC_HI: begin
                w_cnt_run = 1'b1;
                w_sym     = w_data_sym;
                if (w_sym_end) begin
                    w_shift_nxt     = {1'b0, r_shift[8:1]};
                    w_bit_idx_nxt   = r_bit_idx + 4'd1;
                    w_prev_zero_nxt = ~r_shift[0];
                end
                if (w_byte_end) begin
                    w_state_nxt = ST_EOF0;
                end
            end
`endif

            ST_EOF0: begin
                w_cnt_run = 1'b1;
                w_sym     = r_prev_zero ? MILLER_Z : MILLER_Y;
                if (w_sym_end) begin
                    w_prev_zero_nxt = 1'b1;
                    w_state_nxt     = ST_EOF1;
                end
            end

            ST_EOF1: begin
                w_cnt_run = 1'b1;
                w_sym     = MILLER_Y;
                if (w_sym_end) begin
                    w_state_nxt = ST_GAP;
                end
            end

            ST_GAP: begin
                if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A newly accepted byte replaces whatever the symbol engine computed
        if (w_load_byte) begin
            w_shift_nxt   = {odd_parity(in_data[7:0]), in_data[7:0]};
            w_bit_idx_nxt = 4'd0;
            w_last_nxt    = in_data[8];
        end

        w_cnt_nxt   = (w_cnt_run && !w_sym_end) ? (r_cnt + CNT_W'(1)) : '0;
        w_pause_nxt = miller_pause(w_sym, r_cnt);
    end

    assign in_rdy       = w_in_rdy;
    assign tx_pause     = r_tx_pause;
    assign busy         = r_busy;
    assign err_underrun = r_err;

endmodule
